// File: rtl/jtframe_sdram_pkg.sv
// Shared types for the SDRAM read arbiter: FSM state encoding and the
// round-robin pointer increment used after each completed read.
package jtframe_sdram_pkg;

   localparam int STW = 2;

   typedef enum logic [STW-1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   // Slot index following idx, wrapping from slots-1 back to 0.
   function automatic int next_slot(input int idx, input int slots);
      return (idx >= slots - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational round-robin picker: returns the first asserted bit of pend
// at or above ptr, searching upward and wrapping from SLOTS-1 to 0.
module jtframe_rr_pick #(
   parameter int SLOTS = 4,
   parameter int IW    = $clog2(SLOTS)
) (
   input  logic [SLOTS-1:0] pend,
   input  logic [IW-1:0]    ptr,
   output logic             found,
   output logic [IW-1:0]    idx
);

   // Scan SLOTS positions starting at ptr; the first pending one wins.
   always_comb begin
      int j;
      // NOTE: every variable gets a default before the loop, so no path leaves it unassigned and no latch is inferred.
      found = 1'b0;
      idx   = '0;
      j     = 0;
      for (int k = 0; k < SLOTS; k++) begin
         j = int'(ptr) + k;
         if (j >= SLOTS) j = j - SLOTS;
         if (!found && pend[j]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/jtframe_sdram_rrarb.sv
// Round-robin read arbiter sharing one SDRAM controller port among several
// read-only video fetchers. Each slot keeps the last word it read and the
// address it came from; a slot whose request matches that pair is answered
// with no SDRAM access.
//
// Optional build macro: JTFRAME_SDRAM_CACHE_EN
//   defined   - per-slot valid survives a falling cs, so re-requesting the
//               same address hits immediately; valid clears only on reset.
//   undefined - valid clears while cs is low, so every new cs reads SDRAM.
module jtframe_sdram_rrarb
   import jtframe_sdram_pkg::*;
#(
   parameter int SLOTS = 4,
   parameter int AW    = 22,
   parameter int DW    = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SLOTS-1:0]    slot_cs,
   input  logic [SLOTS*AW-1:0] slot_addr,
   output logic [SLOTS-1:0]    slot_ok,
   output logic [SLOTS*DW-1:0] slot_dout,
   output logic                sdram_req,
   output logic [AW-1:0]       sdram_addr,
   input  logic                sdram_ack,
   input  logic                data_rdy,
   input  logic [DW-1:0]       data_read,
   output logic                refresh_en,
   output logic                busy
);

   localparam int IW = $clog2(SLOTS);

   state_t           state;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    pick_idx;
   logic             pick_found;
   logic [SLOTS-1:0] valid;
   logic [SLOTS-1:0] hit;
   logic [SLOTS-1:0] pend;
   logic [AW-1:0]    last_addr [SLOTS];
   logic             complete;

   // A slot hits when its stored word belongs to the address it now presents.
   always_comb begin
      hit = '0;
      for (int i = 0; i < SLOTS; i++) begin
         hit[i] = valid[i] && (last_addr[i] == slot_addr[i*AW +: AW]);
      end
   end

   assign slot_ok = slot_cs & hit;
   assign pend    = slot_cs & ~hit;
   assign busy    = (state != IDLE);

   // Read data is taken in WAIT, or in REQ when ack and data arrive together.
   assign complete = data_rdy &&
                     ((state == WAIT) || ((state == REQ) && sdram_req && sdram_ack));

   jtframe_rr_pick #(
      .SLOTS (SLOTS),
      .IW    (IW)
   ) u_pick (
      .pend  (pend),
      .ptr   (ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Grant/handshake FSM plus the per-slot data, address and valid stores.
   // sdram_req rises one cycle after sdram_addr is latched, giving the
   // controller a full cycle of stable address before the request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         ptr        <= '0;
         sdram_req  <= 1'b0;
         sdram_addr <= '0;
         slot_dout  <= '0;
         valid      <= '0;
         // NOTE: last_addr is a handful of flops, not a RAM, so it is reset like any other register.
         for (int i = 0; i < SLOTS; i++) last_addr[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let later statements override earlier ones while every read sees pre-edge values.
`ifndef JTFRAME_SDRAM_CACHE_EN
         for (int i = 0; i < SLOTS; i++) begin
            if (!slot_cs[i]) valid[i] <= 1'b0;
         end
`endif
         if (complete) begin
            slot_dout[int'(idx)*DW +: DW] <= data_read;
            last_addr[idx]                <= sdram_addr;
            valid[idx]                    <= 1'b1;
            ptr                           <= IW'(next_slot(int'(idx), SLOTS));
         end
         case (state)
            IDLE: begin
               if (pick_found) begin
                  idx        <= pick_idx;
                  sdram_addr <= slot_addr[int'(pick_idx)*AW +: AW];
                  state      <= REQ;
               end
            end
            REQ: begin
               if (!sdram_req) begin
                  sdram_req <= 1'b1;
               end else if (sdram_ack) begin
                  sdram_req <= 1'b0;
                  state     <= data_rdy ? IDLE : WAIT;
               end
            end
            WAIT: begin
               if (data_rdy) state <= IDLE;
            end
            default: begin
               sdram_req <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   // Refresh may be slotted in only while nothing is in flight or waiting.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) refresh_en <= 1'b0;
      else        refresh_en <= (state == IDLE) && !(|pend);
   end

endmodule

// File: tb/tb_jtframe_sdram_rrarb.sv
// Directed self-checking bench for jtframe_sdram_rrarb with a small
// controller model that acks on the cycle it sees sdram_req and returns
// data rdy_n cycles after the ack (same cycle as ack when rdy_n is 0).
module tb_jtframe_sdram_rrarb;

   localparam int SLOTS = 4;
   localparam int AW    = 22;
   localparam int DW    = 32;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [SLOTS-1:0]    slot_cs;
   logic [SLOTS*AW-1:0] slot_addr;
   logic [SLOTS-1:0]    slot_ok;
   logic [SLOTS*DW-1:0] slot_dout;
   logic                sdram_req;
   logic [AW-1:0]       sdram_addr;
   logic                sdram_ack;
   logic                data_rdy;
   logic [DW-1:0]       data_read;
   logic                refresh_en;
   logic                busy;

   int n_checks = 0;
   int n_errors = 0;

   int            rdy_n;
   logic          use_fixed;
   logic [DW-1:0] fixed_data;
   logic [AW-1:0] req_log [$];
   int            req_cnt;

   always #5 clk = ~clk;

   jtframe_sdram_rrarb #(
      .SLOTS (SLOTS),
      .AW    (AW),
      .DW    (DW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .slot_cs    (slot_cs),
      .slot_addr  (slot_addr),
      .slot_ok    (slot_ok),
      .slot_dout  (slot_dout),
      .sdram_req  (sdram_req),
      .sdram_addr (sdram_addr),
      .sdram_ack  (sdram_ack),
      .data_rdy   (data_rdy),
      .data_read  (data_read),
      .refresh_en (refresh_en),
      .busy       (busy)
   );

   function automatic logic [DW-1:0] model(input logic [AW-1:0] a);
      return 32'h5A00_0000 ^ {{(DW-AW){1'b0}}, a};
   endfunction

   function automatic logic [DW-1:0] resp(input logic [AW-1:0] a);
      return use_fixed ? fixed_data : model(a);
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] dout_of(input int s);
      return slot_dout[s*DW +: DW];
   endfunction

   // Controller model
   initial begin
      logic [AW-1:0] cur_addr;
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      data_read = '0;
      forever begin
         @(negedge clk);
         if (rst_n && sdram_req) begin
            cur_addr = sdram_addr;
            req_log.push_back(cur_addr);
            req_cnt++;
            sdram_ack = 1'b1;
            if (rdy_n == 0) begin
               data_rdy  = 1'b1;
               data_read = resp(cur_addr);
            end
            @(negedge clk);
            sdram_ack = 1'b0;
            data_rdy  = 1'b0;
            if (rdy_n > 0) begin
               repeat (rdy_n - 1) @(negedge clk);
               data_rdy  = 1'b1;
               data_read = resp(cur_addr);
               @(negedge clk);
               data_rdy  = 1'b0;
            end
         end
      end
   end

   task automatic do_reset();
      rst_n     = 1'b0;
      slot_cs   = '0;
      slot_addr = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      req_log.delete();
      req_cnt = 0;
   endtask

   task automatic wait_ok(input logic [SLOTS-1:0] mask, input int budget, input string tag);
      int n = 0;
      while (((slot_ok & mask) != mask) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 64'((slot_ok & mask) == mask), 64'd1);
   endtask

   initial begin
      int n;
      rdy_n      = 5;
      use_fixed  = 1'b0;
      fixed_data = '0;
      req_cnt    = 0;

      // Reset values
      rst_n     = 1'b0;
      slot_cs   = '0;
      slot_addr = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_ok",    64'(slot_ok),    64'd0);
      check("rst_dout",  64'(slot_dout),  64'd0);
      check("rst_req",   64'(sdram_req),  64'd0);
      check("rst_addr",  64'(sdram_addr), 64'd0);
      check("rst_busy",  64'(busy),       64'd0);
      check("rst_refr",  64'(refresh_en), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_refr", 64'(refresh_en), 64'd1);

      // Single slot, ack immediately, data 5 cycles after ack: ok 8 cycles after cs
      do_reset();
      rdy_n      = 5;
      use_fixed  = 1'b1;
      fixed_data = 32'hDEAD_BEEF;
      slot_cs[2] = 1'b1;
      slot_addr[2*AW +: AW] = 22'h0A_8000;
      repeat (7) @(negedge clk);
      check("single_ok_c7", 64'(slot_ok[2]), 64'd0);
      @(negedge clk);
      check("single_ok_c8",  64'(slot_ok[2]), 64'd1);
      check("single_dout",   64'(dout_of(2)), 64'hDEAD_BEEF);
      repeat (5) @(negedge clk);
      check("single_reqcnt", 64'(req_cnt), 64'd1);
      check("single_addr",   64'(req_log.size() > 0 ? req_log[0] : '1), 64'h0A_8000);
      slot_cs[2] = 1'b0;
      #1;
      check("single_ok_drop", 64'(slot_ok[2]), 64'd0);
      use_fixed = 1'b0;

      // All four slots together from ptr 0
      do_reset();
      rdy_n = 1;
      slot_addr[0*AW +: AW] = 22'h00_1000;
      slot_addr[1*AW +: AW] = 22'h01_2000;
      slot_addr[2*AW +: AW] = 22'h02_3000;
      slot_addr[3*AW +: AW] = 22'h03_4000;
      slot_cs = 4'b1111;
      wait_ok(4'b1111, 200, "all4");
      check("all4_cnt", 64'(req_cnt), 64'd4);
      if (req_log.size() >= 4) begin
         check("all4_g0", 64'(req_log[0]), 64'h00_1000);
         check("all4_g1", 64'(req_log[1]), 64'h01_2000);
         check("all4_g2", 64'(req_log[2]), 64'h02_3000);
         check("all4_g3", 64'(req_log[3]), 64'h03_4000);
      end
      check("all4_d0", 64'(dout_of(0)), 64'h5A00_1000);
      check("all4_d3", 64'(dout_of(3)), 64'h5A03_4000);
      // Re-request slots 0 and 3 with new addresses: slot 0 must go first
      @(negedge clk);
      slot_cs[0] = 1'b0;
      slot_cs[3] = 1'b0;
      @(negedge clk);
      slot_addr[0*AW +: AW] = 22'h00_1004;
      slot_addr[3*AW +: AW] = 22'h03_4004;
      slot_cs[0] = 1'b1;
      slot_cs[3] = 1'b1;
      wait_ok(4'b1001, 200, "rr03");
      check("rr03_cnt", 64'(req_cnt), 64'd6);
      if (req_log.size() >= 6) begin
         check("rr03_g4", 64'(req_log[4]), 64'h00_1004);
         check("rr03_g5", 64'(req_log[5]), 64'h03_4004);
      end
      check("rr03_d3", 64'(dout_of(3)), 64'h5A03_4004);

      // Address change while slot 1 is waiting for data
      do_reset();
      rdy_n = 5;
      slot_addr[1*AW +: AW] = 22'h3B_0000;
      slot_cs[1] = 1'b1;
      n = 0;
      while (req_cnt < 1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("achg_req1_timeout", 64'(req_cnt >= 1), 64'd1);
      @(negedge clk);
      slot_addr[1*AW +: AW] = 22'h3B_0002;
      n = 0;
      while (!slot_ok[1] && n < 80) begin
         @(negedge clk);
         n++;
      end
      check("achg_ok_timeout", 64'(slot_ok[1]), 64'd1);
      check("achg_reqcnt",     64'(req_cnt), 64'd2);
      check("achg_addr2",      64'(req_log.size() >= 2 ? req_log[1] : '1), 64'h3B_0002);
      check("achg_dout",       64'(dout_of(1)), 64'h5A3B_0002);

      // Same-cycle ack and data_rdy
      do_reset();
      rdy_n = 0;
      slot_addr[0*AW +: AW] = 22'h12_3450;
      slot_cs[0] = 1'b1;
      @(negedge clk);
      check("same_busy_c1", 64'(busy), 64'd1);
      @(negedge clk);
      check("same_ok_c2",   64'(slot_ok[0]), 64'd0);
      @(negedge clk);
      check("same_ok_c3",   64'(slot_ok[0]), 64'd1);
      check("same_busy_c3", 64'(busy), 64'd0);
      check("same_dout",    64'(dout_of(0)), 64'h5A12_3450);
      repeat (6) @(negedge clk);
      check("same_reqcnt",  64'(req_cnt), 64'd1);

      // Reset pulse during WAIT, stale data_rdy 2 cycles after release
      do_reset();
      rdy_n = 5;
      slot_addr[0*AW +: AW] = 22'h15_5554;
      slot_cs[0] = 1'b1;
      repeat (3) @(negedge clk);
      check("rstw_busy", 64'(busy), 64'd1);
      check("rstw_req",  64'(sdram_req), 64'd0);
      @(negedge clk);
      rst_n   = 1'b0;
      slot_cs = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("rstw_ok",   64'(slot_ok), 64'd0);
      check("rstw_dout", 64'(slot_dout), 64'd0);
      check("rstw_refr", 64'(refresh_en), 64'd1);
      check("rstw_idle", 64'(busy), 64'd0);

      // cs low then high on slot 0 at the same address
      do_reset();
      rdy_n = 2;
      slot_addr[0*AW +: AW] = 22'h2A_AAA8;
      slot_cs[0] = 1'b1;
      wait_ok(4'b0001, 40, "rehit_first");
      check("rehit_cnt1", 64'(req_cnt), 64'd1);
      @(negedge clk);
      slot_cs[0] = 1'b0;
      #1;
      check("rehit_ok_low", 64'(slot_ok[0]), 64'd0);
      @(negedge clk);
      @(negedge clk);
      slot_cs[0] = 1'b1;
      #1;
`ifdef JTFRAME_SDRAM_CACHE_EN
      check("rehit_ok_now", 64'(slot_ok[0]), 64'd1);
      repeat (10) @(negedge clk);
      check("rehit_cnt2",   64'(req_cnt), 64'd1);
`else
      check("rehit_ok_now", 64'(slot_ok[0]), 64'd0);
      wait_ok(4'b0001, 40, "rehit_second");
      check("rehit_cnt2",   64'(req_cnt), 64'd2);
`endif
      check("rehit_dout",   64'(dout_of(0)), 64'h5A2A_AAA8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
